tour_move_sequencer: RTL

Sequences a solved Knight's Tour into robot motion. After a tour solution is written into move memory, this block reads one knight move at a time, splits it into two straight-line move commands, issues them to the command processor with a handshake, and waits for completion. It reports progress on the response channel and sits between the tour solver's move memory and the command processor.

---
 rtl/tour_move_sequencer_pkg.sv | 34 +++
 rtl/tour_move_sequencer_if.sv | 27 ++
 rtl/tour_move_sequencer_knight_move_decode.sv | 29 ++
 rtl/tour_move_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/tour_move_sequencer_pkg.sv
// Shared constants for Knight's Tour playback: headings, response codes,
// FSM state encodings and the move-command builder.
package tour_pkg;

    localparam logic [7:0] HEAD_NORTH = 8'h00;
    localparam logic [7:0] HEAD_WEST  = 8'h3F;
    localparam logic [7:0] HEAD_SOUTH = 8'h7F;
    localparam logic [7:0] HEAD_EAST  = 8'hBF;

    localparam logic [7:0] COMM_COMPLETE     = 8'hA5;
    localparam logic [7:0] COMM_INTERMEDIATE = 8'h5A;
    localparam logic [7:0] COMM_ERR          = 8'hEE;

    localparam logic [3:0] SQ_LONG  = 4'd2;
    localparam logic [3:0] SQ_SHORT = 4'd1;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_LEG1   = 4'd3;
    localparam logic [3:0] ST_WAIT1  = 4'd4;
    localparam logic [3:0] ST_LEG2   = 4'd5;
    localparam logic [3:0] ST_WAIT2  = 4'd6;
    localparam logic [3:0] ST_RESP   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    // Opcode nibble is 4'b0010, with bit 0 raised for the fanfare leg.
    function automatic logic [15:0] build_cmd(input logic       fanfare,
                                              input logic [7:0] heading,
                                              input logic [3:0] squares);
        return {3'b001, fanfare, heading, squares};
    endfunction

endpackage

// File: rtl/tour_move_sequencer_if.sv
// Bundle of the move-memory, command and response channels of the sequencer.
// Handshake: cmd_vld is a one-cycle pulse, cmd holds until the matching cmd_done pulse.
interface tour_move_sequencer_if #(parameter int ADDR_W = 5);

    logic              go;
    logic [ADDR_W-1:0] mv_addr;
    logic [7:0]        mv_data;
    logic [15:0]       cmd;
    logic              cmd_vld;
    logic              cmd_done;
    logic [7:0]        resp;
    logic              resp_vld;
    logic              busy;
    logic              err;
    logic [3:0]        dbg_state;

    modport master (
        input  go, mv_data, cmd_done,
        output mv_addr, cmd, cmd_vld, resp, resp_vld, busy, err, dbg_state
    );

    modport slave (
        output go, mv_data, cmd_done,
        input  mv_addr, cmd, cmd_vld, resp, resp_vld, busy, err, dbg_state
    );

endinterface

// File: rtl/tour_move_sequencer_knight_move_decode.sv
// Splits a one-hot knight move into a 2-square leg and a 1-square fanfare leg.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  mv_data,
    output logic [15:0] leg1,
    output logic [15:0] leg2,
    output logic        vld
);

    always_comb begin
        vld  = (mv_data != 8'h00) && ((mv_data & (mv_data - 8'd1)) == 8'h00);
        leg1 = 16'h0000;
        leg2 = 16'h0000;
        // Leg 1 always runs along the |2| axis, leg 2 along the |1| axis.
        case (mv_data)
            8'h01: begin leg1 = build_cmd(1'b0, HEAD_NORTH, SQ_LONG); leg2 = build_cmd(1'b1, HEAD_EAST,  SQ_SHORT); end
            8'h02: begin leg1 = build_cmd(1'b0, HEAD_NORTH, SQ_LONG); leg2 = build_cmd(1'b1, HEAD_WEST,  SQ_SHORT); end
            8'h04: begin leg1 = build_cmd(1'b0, HEAD_WEST,  SQ_LONG); leg2 = build_cmd(1'b1, HEAD_NORTH, SQ_SHORT); end
            8'h08: begin leg1 = build_cmd(1'b0, HEAD_WEST,  SQ_LONG); leg2 = build_cmd(1'b1, HEAD_SOUTH, SQ_SHORT); end
            8'h10: begin leg1 = build_cmd(1'b0, HEAD_SOUTH, SQ_LONG); leg2 = build_cmd(1'b1, HEAD_WEST,  SQ_SHORT); end
            8'h20: begin leg1 = build_cmd(1'b0, HEAD_SOUTH, SQ_LONG); leg2 = build_cmd(1'b1, HEAD_EAST,  SQ_SHORT); end
            8'h40: begin leg1 = build_cmd(1'b0, HEAD_EAST,  SQ_LONG); leg2 = build_cmd(1'b1, HEAD_SOUTH, SQ_SHORT); end
            8'h80: begin leg1 = build_cmd(1'b0, HEAD_EAST,  SQ_LONG); leg2 = build_cmd(1'b1, HEAD_NORTH, SQ_SHORT); end
            default: ;
        endcase
    end

endmodule

// File: rtl/tour_move_sequencer.sv
// Plays a stored Knight's Tour back as pairs of straight-line commands,
// waiting for each leg to complete and reporting progress per move.
module tour_move_sequencer
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int ADDR_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    tour_move_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_MOVES - 1);

    logic [3:0]        state;
    logic [ADDR_W-1:0] mv_addr;
    logic [15:0]       cmd;
    logic              cmd_vld;
    logic [7:0]        resp;
    logic              resp_vld;
    logic              err;
    logic [15:0]       leg1_q;
    logic [15:0]       leg2_q;
    logic [15:0]       dec_leg1;
    logic [15:0]       dec_leg2;
    logic              dec_vld;

    knight_move_decode u_decode (
        .mv_data (bus.mv_data),
        .leg1    (dec_leg1),
        .leg2    (dec_leg2),
        .vld     (dec_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mv_addr  <= '0;
            cmd      <= 16'h0000;
            cmd_vld  <= 1'b0;
            resp     <= 8'h00;
            resp_vld <= 1'b0;
            err      <= 1'b0;
            leg1_q   <= 16'h0000;
            leg2_q   <= 16'h0000;
        end else begin
            cmd_vld  <= 1'b0;
            resp_vld <= 1'b0;
            case (state)
                ST_IDLE: if (bus.go) begin
                    state   <= ST_FETCH;
                    mv_addr <= '0;
                    err     <= 1'b0;
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: if (dec_vld) begin
                    leg1_q <= dec_leg1;
                    leg2_q <= dec_leg2;
                    state  <= ST_LEG1;
                end else begin
                    err      <= 1'b1;
                    resp     <= COMM_ERR;
                    resp_vld <= 1'b1;
                    state    <= ST_IDLE;
                end
                ST_LEG1: begin
                    cmd     <= leg1_q;
                    cmd_vld <= 1'b1;
                    state   <= ST_WAIT1;
                end
                // A done arriving alongside our own cmd_vld pulse belongs to nothing.
                ST_WAIT1: if (bus.cmd_done && !cmd_vld) state <= ST_LEG2;
                ST_LEG2: begin
                    cmd     <= leg2_q;
                    cmd_vld <= 1'b1;
                    state   <= ST_WAIT2;
                end
                ST_WAIT2: if (bus.cmd_done && !cmd_vld) state <= ST_RESP;
                ST_RESP: if (mv_addr == LAST_ADDR) begin
                    state <= ST_DONE;
                end else begin
                    resp     <= COMM_INTERMEDIATE;
                    resp_vld <= 1'b1;
                    mv_addr  <= mv_addr + 1'b1;
                    state    <= ST_FETCH;
                end
                ST_DONE: begin
                    resp     <= COMM_COMPLETE;
                    resp_vld <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mv_addr   = mv_addr;
    assign bus.cmd       = cmd;
    assign bus.cmd_vld   = cmd_vld;
    assign bus.resp      = resp;
    assign bus.resp_vld  = resp_vld;
    assign bus.err       = err;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.dbg_state = state;

endmodule
